// File: rtl/usart_rx_buffer.sv
// Receive-side byte FIFO for a USART with registered RTS hysteresis flow control.
// Optional sticky overrun flag is enabled by defining USART_RX_OVERRUN_FLAG_EN.
module usart_rx_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned HIGH_WATER = 12,
    parameter int unsigned LOW_WATER  = 4
) (
    input  logic                  comm_clock,
    input  logic                  comm_reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fill_count,
    output logic                  rts_pin,
    output logic                  overrun,
    input  logic                  overrun_clear
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] HW_LEVEL = (DEPTH_LOG2 + 1)'(HIGH_WATER);
    localparam logic [DEPTH_LOG2:0] LW_LEVEL = (DEPTH_LOG2 + 1)'(LOW_WATER);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   next_count;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  overrun_evt;

    // fill_count never exceeds DEPTH, so its MSB alone marks the full state
    assign full        = fill_count[DEPTH_LOG2];
    assign out_valid   = (fill_count != '0);
    assign out_data    = mem[rd_ptr];
    assign pop         = out_valid && out_ready;
    assign push        = rx_valid && (!full || pop);
    assign overrun_evt = rx_valid && full && !pop;

    always_comb begin
        next_count = fill_count;
        case ({push, pop})
            2'b10:   next_count = fill_count + 1'b1;
            2'b01:   next_count = fill_count - 1'b1;
            default: next_count = fill_count;
        endcase
    end

    always_ff @(posedge comm_clock) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge comm_clock or negedge comm_reset_n) begin
        if (!comm_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            rts_pin    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill_count <= next_count;
            // Hysteresis: between the thresholds rts_pin keeps its value
            if (next_count >= HW_LEVEL) begin
                rts_pin <= 1'b1;
            end else if (next_count <= LW_LEVEL) begin
                rts_pin <= 1'b0;
            end
        end
    end

`ifdef USART_RX_OVERRUN_FLAG_EN
    always_ff @(posedge comm_clock or negedge comm_reset_n) begin
        if (!comm_reset_n) begin
            overrun <= 1'b0;
        end else if (overrun_evt) begin
            overrun <= 1'b1;
        end else if (overrun_clear) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_overrun_sig;
    assign unused_overrun_sig = overrun_clear ^ overrun_evt;
    assign overrun            = 1'b0;
`endif

endmodule

// File: doc/usart_rx_buffer.md
USART_RX_BUFFER -- requirements
Module: usart_rx_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, sets FIFO depth to 2**DEPTH_LOG2 bytes (16).
REQ-002 Parameter HIGH_WATER, default 12, is the fill level at which flow control halts the sender.
REQ-003 Parameter LOW_WATER, default 4, is the fill level at which flow control releases the sender; LOW_WATER < HIGH_WATER <= depth.
REQ-004 comm_clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 comm_reset_n  in  1  asynchronous, active-low reset.
REQ-006 rx_data  in  8  received byte from the upstream USART receiver.
REQ-007 rx_valid  in  1  one-cycle strobe; rx_data is valid while it is high.
REQ-008 out_data  out  8  head-of-FIFO byte to the consumer.
REQ-009 out_valid  out  1  high when out_data holds a valid byte.
REQ-010 out_ready  in  1  consumer accepts the byte when out_valid and out_ready are both high.
REQ-011 fill_count  out  DEPTH_LOG2+1  number of bytes currently stored.
REQ-012 rts_pin  out  1  flow control to the remote sender: 0 = may send, 1 = hold off.
REQ-013 overrun  out  1  sticky overrun flag (see Configuration).
REQ-014 overrun_clear  in  1  synchronous clear of overrun.

Function
REQ-015 Storage is a circular buffer of 2**DEPTH_LOG2 x 8 bits with read/write pointers that wrap modulo depth.
REQ-016 Push: on a rising edge with rx_valid=1 and the FIFO not full, rx_data is written at the write pointer and the write pointer advances.
REQ-017 Pop: on a rising edge with out_valid=1 and out_ready=1, the read pointer advances.
REQ-018 Output is first-word-fall-through: out_data always shows the byte at the read pointer; out_valid = (fill_count != 0).
REQ-019 Latency: a byte pushed into an empty FIFO appears on out_data/out_valid one cycle after the push edge; there is no same-cycle bypass.
REQ-020 Simultaneous push and pop when not empty: both occur, fill_count unchanged.
REQ-021 Simultaneous push and pop when full: both occur, byte accepted, fill_count stays at depth, no overrun.
REQ-022 Push when empty with out_ready=1: only the push occurs (out_valid was 0).
REQ-023 Push when full without pop: byte discarded, pointers and fill_count unchanged, overrun event raised.
REQ-024 out_ready with out_valid=0 has no effect; fill_count never underflows.
REQ-025 fill_count is registered and reflects the result of the push/pop on the same edge.
REQ-026 rts_pin is registered with hysteresis: it goes to 1 on the edge where the new fill_count >= HIGH_WATER and returns to 0 on the edge where the new fill_count <= LOW_WATER; between the thresholds it holds its value.
REQ-027 Bytes arriving while rts_pin=1 are still accepted if space remains.

Reset
REQ-028 While comm_reset_n=0, immediately and independent of comm_clock: pointers=0, fill_count=0, out_valid=0, rts_pin=0, overrun=0.
REQ-029 Reset mid-operation discards all stored bytes; out_data content is don't-care while out_valid=0.
REQ-030 Normal operation resumes on the first rising edge after comm_reset_n returns high.

Configuration
REQ-031 Macro USART_RX_OVERRUN_FLAG_EN defined: overrun is set on the edge of an overrun event (REQ-023), stays set until an edge with overrun_clear=1, and a set on the same edge as a clear wins (overrun stays 1).
REQ-032 Macro USART_RX_OVERRUN_FLAG_EN undefined: overrun is constant 0, overrun_clear is ignored, and the discard behaviour of REQ-023 is unchanged.

Verification
REQ-033 Reset, then push 0x75 with out_ready=0 -> next cycle out_valid=1, out_data=0x75, fill_count=1, rts_pin=0.
REQ-034 Push 0x00..0x0F (16 bytes) with out_ready=0 -> fill_count=16, rts_pin=1 from the edge of the 12th push; a 17th push of 0xAA is dropped and overrun=1 (macro on) or 0 (macro off).
REQ-035 From full, set out_ready=1 and drain -> bytes read in order 0x00..0x0F, rts_pin returns to 0 on the edge where fill_count becomes 4, out_valid=0 after 16 pops.
REQ-036 Full FIFO, push 0x5A on the same edge as a pop -> fill_count stays 16, overrun unchanged, 0x5A is read out last after draining.
REQ-037 Wrap-around: push/pop 40 bytes 0x80..0xA7 with out_ready=1 continuously -> every byte out in order, fill_count never exceeds 1.
REQ-038 Assert comm_reset_n=0 asynchronously with fill_count=10 and rts_pin=0 -> fill_count=0, out_valid=0, rts_pin=0, overrun=0 before the next clock edge.
